// File: rtl/uart_telemetry_framer_if.sv
// Framer-side handshake bundle: telemetry FIFO read port, uart_tx byte port, status outputs.
// The framer connects through master; the FIFO/UART environment connects through slave.
interface uart_telemetry_framer_if #(
  parameter int W         = 64,
  parameter int CNT_WIDTH = 16
) ();
  logic                 fsm_en;
  logic                 fifo_empty;
  logic [W-1:0]         fifo_rd_data;
  logic                 fifo_rd_en;
  logic                 uart_tx_done;
  logic                 uart_start_tx;
  logic [7:0]           uart_tx_din;
  logic                 busy;
  logic [CNT_WIDTH-1:0] frame_count;

  modport master (
    input  fsm_en, fifo_empty, fifo_rd_data, uart_tx_done,
    output fifo_rd_en, uart_start_tx, uart_tx_din, busy, frame_count
  );

  modport slave (
    output fsm_en, fifo_empty, fifo_rd_data, uart_tx_done,
    input  fifo_rd_en, uart_start_tx, uart_tx_din, busy, frame_count
  );
endinterface

// File: rtl/uart_telemetry_framer.sv
// Pops one telemetry word per frame and sends it to uart_tx as
// sync byte, payload bytes MSB-first, then an XOR checksum of the payload.
module uart_telemetry_framer #(
  parameter int         FIFO_RD_DATA_WIDTH = 64,
  parameter logic [7:0] SYNC_BYTE          = 8'hA5,
  parameter int         CNT_WIDTH          = 16
) (
  input logic                    clk,
  input logic                    reset,
  uart_telemetry_framer_if.master bus
);

  localparam int W      = FIFO_RD_DATA_WIDTH;
  localparam int NBYTES = W / 8;
  localparam int IDX_W  = $clog2(NBYTES + 2);
  localparam logic [IDX_W-1:0] NB_IDX   = IDX_W'(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES + 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, SEND, WAIT_DONE} state_t;

  state_t               state_q;
  logic [W-1:0]         word_q;
  logic [7:0]           chk_q;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           din_q;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

  // Payload byte k (1..NBYTES) counted from the MSB end of the word.
  function automatic logic [7:0] payload_byte(input logic [W-1:0] w, input logic [IDX_W-1:0] k);
    logic [W-1:0] sh;
    sh = w >> (W - 8 * int'(k));
    return sh[7:0];
  endfunction

  function automatic logic [7:0] byte_sel(input logic [IDX_W-1:0] k, input logic [W-1:0] w,
                                          input logic [7:0] chk);
    if (k == '0)          return SYNC_BYTE;
    else if (k <= NB_IDX) return payload_byte(w, k);
    else                  return chk;
  endfunction

  assign idx_d       = idx_q + IDX_W'(1);
  assign frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      chk_q       <= '0;
      idx_q       <= '0;
      din_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.fsm_en && !bus.fifo_empty) state_q <= POP;
        POP:  state_q <= LOAD;
        LOAD: begin
          word_q  <= bus.fifo_rd_data;
          idx_q   <= '0;
          chk_q   <= '0;
          din_q   <= SYNC_BYTE;
          state_q <= SEND;
        end
        SEND: begin
          if (idx_q != '0 && idx_q <= NB_IDX) chk_q <= chk_q ^ payload_byte(word_q, idx_q);
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // The next byte is staged here so din is already valid in the SEND cycle.
          if (bus.uart_tx_done) begin
            if (idx_q == LAST_IDX) begin
              frame_cnt_q <= frame_cnt_d;
              state_q     <= IDLE;
            end else begin
              idx_q   <= idx_d;
              din_q   <= byte_sel(idx_d, word_q, chk_q);
              state_q <= SEND;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fifo_rd_en    = (state_q == POP);
  assign bus.uart_start_tx = (state_q == SEND);
  assign bus.busy          = (state_q != IDLE);
  assign bus.uart_tx_din   = din_q;
  assign bus.frame_count   = frame_cnt_q;

endmodule
